round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//  Match/round controller for the two-player light-cycle game. Sequences the arena
//  datapath (grid clear, movement steps, collision check), paces steps with a
//  programmable timer, keeps scores and declares the round/match winner. Sits
//  between the player/arena datapath and top level, all logic on CLOCK_50.
// PARAMETERS
//  STEP_CYCLES       2_500_000    CLOCK_50 cycles between step requests (50 ms)
//  COUNTDOWN_CYCLES  50_000_000   cycles per countdown unit (1 s), 3 units before play
//  ROUND_END_CYCLES  100_000_000  hold time showing round result before next clear
//  WIN_SCORE         5            points to win match (1..15)
//  TMR_W             27           timer width; must hold max(above cycle counts)
// PORTS
//  CLOCK_50      in   1   system clock
//  reset         in   1   synchronous, active-high
//  start         in   1   level; rising edge starts match / next match
//  pause         in   1   level; freezes step timer while in RUN
//  clear_done    in   1   datapath finished grid clear (pulse or level)
//  step_done     in   1   1-cycle pulse: step finished, crash flags valid this cycle
//  crash_p1      in   1   player 1 collided on this step (sampled with step_done)
//  crash_p2      in   1   player 2 collided on this step (sampled with step_done)
//  clear_req     out  1   held high until clear_done seen
//  step_req      out  1   1-cycle pulse: datapath performs one movement step
//  round_active  out  1   high in RUN and STEP_WAIT (datapath accepts key turns)
//  countdown     out  2   3,2,1 during COUNTDOWN, else 0
//  score_p1      out  4   player 1 score
//  score_p2      out  4   player 2 score
//  winner        out  2   last round: 0 none, 1 P1, 2 P2, 3 draw
//  match_over    out  1   high in MATCH_END
//  state_o       out  3   current state encoding (debug/LEDs)
// BEHAVIOUR
//  reset (sync, active-high) → IDLE, all outputs 0, timer 0, start edge detector cleared; wins over every input.
//  start edge = start & ~start_q (start_q registered). Only edges act; level ignored.
//  States (state_o): IDLE=0 CLEAR=1 COUNTDOWN=2 RUN=3 STEP_WAIT=4 ROUND_END=5 MATCH_END=6.
//  IDLE: start edge → CLEAR; scores and winner zeroed on that transition.
//  CLEAR: clear_req=1 from entry cycle. clear_done=1 → clear_req=0 next cycle, go COUNTDOWN, timer=0.
//  COUNTDOWN: countdown=3, decrements each COUNTDOWN_CYCLES; after 3rd unit → RUN, timer=0, countdown=0.
//  RUN: timer counts while pause=0; at timer==STEP_CYCLES-1 → step_req pulse (1 cycle), timer=0, go STEP_WAIT.
//    pause=1 holds timer value; no step issued. First step_req STEP_CYCLES cycles after RUN entry.
//  STEP_WAIT: no new step_req. step_done=1 evaluates crash_p1/crash_p2 in that cycle:
//    none → RUN; only p1 → score_p2++, winner=2; only p2 → score_p1++, winner=1;
//    both → winner=3, no score change. Any crash → ROUND_END, timer=0.
//    step_done outside STEP_WAIT ignored; crash flags ignored without step_done.
//  ROUND_END: hold ROUND_END_CYCLES; then if score_p1==WIN_SCORE or score_p2==WIN_SCORE
//    → MATCH_END, else → CLEAR (winner retained until next round's crash).
//  MATCH_END: match_over=1, scores frozen. start edge → clear scores/winner, → CLEAR.
//  Scores saturate at WIN_SCORE, never wrap. Start edges outside IDLE/MATCH_END ignored.
//  Outputs registered; step_req/clear_req change on the cycle after the state transition.
//  Timer: TMR_W bits, reset to 0 at every state entry; never wraps (compare is ==).
// TESTING  (bench params: STEP_CYCLES=4, COUNTDOWN_CYCLES=10, ROUND_END_CYCLES=6, WIN_SCORE=2)
//  1 reset mid-RUN with step_req pending → next cycle state_o=0, all outputs 0, no step_req.
//  2 start edge, clear_done 5 cycles later → clear_req high exactly 5 cycles; countdown 3,2,1 of
//    10 cycles each; first step_req 4 cycles after RUN; step_done w/o crash → step_req every 5 cycles.
//  3 step_done with crash_p1=1 → score_p2=1, winner=2, ROUND_END 6 cycles, then clear_req=1.
//  4 step_done with both crashes → winner=3, scores unchanged; pause=1 for 20 cycles in RUN
//    → no step_req during pause, timer resumes from held value.
//  5 P2 crashes twice → score_p1=2, match_over=1, state_o=6; start held high → no restart
//    until a new rising edge; that edge → scores 0, clear_req=1.
//  6 step_done pulsed in RUN/COUNTDOWN with crash flags → ignored, scores unchanged.

Source files
------------

// File: rtl/round_sequencer.sv
// Match/round controller for the two-player light-cycle game: paces arena
// steps, evaluates crashes, keeps scores and declares round/match winners.
module round_sequencer #(
  parameter int STEP_CYCLES      = 2_500_000,
  parameter int COUNTDOWN_CYCLES = 50_000_000,
  parameter int ROUND_END_CYCLES = 100_000_000,
  parameter int WIN_SCORE        = 5,
  parameter int TMR_W            = 27
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear_done,
  input  logic       step_done,
  input  logic       crash_p1,
  input  logic       crash_p2,
  output logic       clear_req,
  output logic       step_req,
  output logic       round_active,
  output logic [1:0] countdown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic       match_over,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    COUNTDOWN = 3'd2,
    RUN       = 3'd3,
    STEP_WAIT = 3'd4,
    ROUND_END = 3'd5,
    MATCH_END = 3'd6
  } state_t;

  localparam logic [TMR_W-1:0] STEP_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] CD_LAST   = TMR_W'(COUNTDOWN_CYCLES - 1);
  localparam logic [TMR_W-1:0] RE_LAST   = TMR_W'(ROUND_END_CYCLES - 1);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             start_q, start_edge, step_req_n;
  logic [1:0]       countdown_n, winner_n;
  logic [3:0]       score_p1_n, score_p2_n;

  // Next-state, timer, score and pulse computation.
  always_comb begin
    start_edge  = start & ~start_q;
    state_n     = state;
    timer_n     = timer;
    countdown_n = countdown;
    score_p1_n  = score_p1;
    score_p2_n  = score_p2;
    winner_n    = winner;
    step_req_n  = 1'b0;
    case (state)
      IDLE, MATCH_END: begin
        if (start_edge) begin
          state_n    = CLEAR;
          timer_n    = '0;
          score_p1_n = 4'd0;
          score_p2_n = 4'd0;
          winner_n   = 2'd0;
        end else begin
          state_n = state;
        end
      end
      CLEAR: begin
        if (clear_done) begin
          state_n     = COUNTDOWN;
          timer_n     = '0;
          countdown_n = 2'd3;
        end else begin
          state_n = CLEAR;
        end
      end
      COUNTDOWN: begin
        if (timer == CD_LAST) begin
          timer_n = '0;
          if (countdown == 2'd1) begin
            state_n     = RUN;
            countdown_n = 2'd0;
          end else begin
            countdown_n = countdown - 2'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      // Pause only freezes the timer; the held value resumes counting later.
      RUN: begin
        if (pause) begin
          timer_n = timer;
        end else if (timer == STEP_LAST) begin
          state_n    = STEP_WAIT;
          timer_n    = '0;
          step_req_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STEP_WAIT: begin
        if (step_done) begin
          timer_n = '0;
          if (crash_p1 && crash_p2) begin
            winner_n = 2'd3;
            state_n  = ROUND_END;
          end else if (crash_p1) begin
            winner_n   = 2'd2;
            score_p2_n = (score_p2 < WIN) ? score_p2 + 4'd1 : score_p2;
            state_n    = ROUND_END;
          end else if (crash_p2) begin
            winner_n   = 2'd1;
            score_p1_n = (score_p1 < WIN) ? score_p1 + 4'd1 : score_p1;
            state_n    = ROUND_END;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = STEP_WAIT;
        end
      end
      ROUND_END: begin
        if (timer == RE_LAST) begin
          timer_n = '0;
          state_n = (score_p1 == WIN || score_p2 == WIN) ? MATCH_END : CLEAR;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs follow the next state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      start_q      <= 1'b0;
      clear_req    <= 1'b0;
      step_req     <= 1'b0;
      round_active <= 1'b0;
      countdown    <= 2'd0;
      score_p1     <= 4'd0;
      score_p2     <= 4'd0;
      winner       <= 2'd0;
      match_over   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      start_q      <= start;
      clear_req    <= (state_n == CLEAR);
      step_req     <= step_req_n;
      round_active <= (state_n == RUN) || (state_n == STEP_WAIT);
      countdown    <= countdown_n;
      score_p1     <= score_p1_n;
      score_p2     <= score_p2_n;
      winner       <= winner_n;
      match_over   <= (state_n == MATCH_END);
    end
  end

  assign state_o = state;

endmodule
